alu_dest_demux: RTL

- Write-back side of the ALU datapath: takes the ALU result bus and a 3-bit destination code, then commits the value into one of five datapath registers (AC, R1, R5, IDX, IDY).
- Uses the same select encoding as the ALU operand mux, so one control word names the same register on both read and write.
- Two-stage pipeline: capture, then commit.
- Also provides index auto-increment for IDX/IDY, a zero flag and an illegal-code error pulse.

---
 rtl/alu_dest_demux_pkg.sv | 10 +
 rtl/alu_dest_demux_idx_counter.sv | 16 +
 rtl/alu_dest_demux.sv | 62 ++++++
 3 files changed

// File: rtl/alu_dest_demux_pkg.sv
// alu_dest_demux_pkg: shared datapath width and destination codes for the ALU operand mux and write-back demux
package alu_dest_demux_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic [2:0] DST_NONE = 3'b000;
  localparam logic [2:0] DST_AC   = 3'b001;
  localparam logic [2:0] DST_IDX  = 3'b010;
  localparam logic [2:0] DST_IDY  = 3'b011;
  localparam logic [2:0] DST_R1   = 3'b100;
  localparam logic [2:0] DST_R5   = 3'b101;
endpackage

// File: rtl/alu_dest_demux_idx_counter.sv
// idx_counter: index register with priority load and wrapping increment
module idx_counter #(
  parameter int WIDTH = 16,
  parameter int INC_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= ld ? ld_val : inc ? q + WIDTH'(INC_STEP) : q;
endmodule

// File: rtl/alu_dest_demux.sv
// alu_dest_demux: two-stage capture/commit write-back of the ALU bus into AC, R1, R5, IDX, IDY
module alu_dest_demux
  import alu_dest_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int INC_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUOUT_,
  input  logic [2:0]       DEMUX,
  input  logic             wr_en,
  input  logic             inc_x,
  input  logic             inc_y,
  output logic [WIDTH-1:0] AC_,
  output logic [WIDTH-1:0] R1_,
  output logic [WIDTH-1:0] R5_,
  output logic [WIDTH-1:0] IDX_,
  output logic [WIDTH-1:0] IDY_,
  output logic             busy,
  output logic             zero,
  output logic             err
);
  logic             st_vld;
  logic [2:0]       st_dst;
  logic [WIDTH-1:0] st_dat;
  logic             cap, ill;
  assign cap  = wr_en && DEMUX != DST_NONE && DEMUX[2:1] != 2'b11;
  assign ill  = wr_en && DEMUX[2:1] == 2'b11;
  assign busy = st_vld;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_vld <= 1'b0;
      st_dst <= DST_NONE;
      st_dat <= '0;
      err    <= 1'b0;
      zero   <= 1'b0;
      AC_    <= '0;
      R1_    <= '0;
      R5_    <= '0;
    end else begin
      st_vld <= cap;
      err    <= ill;
      if (cap) begin
        st_dst <= DEMUX;
        st_dat <= ALUOUT_;
      end
      if (st_vld) zero <= st_dat == '0;
      if (st_vld && st_dst == DST_AC) AC_ <= st_dat;
      if (st_vld && st_dst == DST_R1) R1_ <= st_dat;
      if (st_vld && st_dst == DST_R5) R5_ <= st_dat;
    end
  // a commit load takes priority over a same-edge increment inside the counter
  idx_counter #(.WIDTH(WIDTH), .INC_STEP(INC_STEP)) u_idx (
    .clk(clk), .rst_n(rst_n), .ld(st_vld && st_dst == DST_IDX),
    .ld_val(st_dat), .inc(inc_x), .q(IDX_)
  );
  idx_counter #(.WIDTH(WIDTH), .INC_STEP(INC_STEP)) u_idy (
    .clk(clk), .rst_n(rst_n), .ld(st_vld && st_dst == DST_IDY),
    .ld_val(st_dat), .inc(inc_y), .q(IDY_)
  );
endmodule
